alu_split_sched: RTL and testbench
==================================

Name: alu_split_sched

Overview:
- Issue-split scheduler in front of the three-slot ALU block (alu0/alu1/alu2 plus the shared regfile).
- Takes one bundle of up to three ALU ops per cycle and detects intra-bundle register dependencies.
- Partitions the bundle into 1–3 issue groups, emitted on consecutive cycles, and back-pressures the front end with do_stall while groups remain.
- Produces per-slot forward/bypass selects for the ALU operand muxes.

Parameters:
- TAG_HI, 4'b1100: upper 4 bits of an ALU result tag. Tag of slot k is {TAG_HI, index_k}.
- CHAIN_OK, 1: 1 means slot1 may consume slot0's result in the same group via the half-cycle path. 0 means it is deferred.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  global pipeline freeze
- bnd_valid  in  1  bundle present
- slot_en  in  3  per-slot op valid
- slot_wen  in  3  per-slot writes an ALU result
- slot_index  in  6  {idx2,idx1,idx0}, 2 bits each
- slot_rA  in  18  {rA2,rA1,rA0}, 6 bits each
- slot_rB  in  18  {rB2,rB1,rB0}, 6 bits each
- do_stall  out  1  upstream must hold bundle
- do_split  out  3  slot k deferred to a group >0
- iss_valid  out  1  issue group valid
- iss_en  out  3  slots issuing this cycle
- iss_fwdA  out  3  operand A from same-group slot0 (only bit1 can be set)
- iss_fwdB  out  3  same, operand B
- iss_prevA  out  3  operand A from the immediately preceding group's result
- iss_prevB  out  3  same, operand B

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low, port name rst.
- Reset: all outputs 0, state IDLE, pending masks cleared. Reset asserted mid-split discards the remaining groups; nothing further issues.
- Accept condition: bnd_valid && !do_stall && !stall. Bundles are captured only on accept.
- Dependency dep(j,i) for i<j: en_j && en_i && wen_i && (rA_j==tag_i || rB_j==tag_i), evaluated per operand.
- Tag collision (idx1==idx0, both wen): slot2 operands bind to slot1 (youngest producer) only.
- Group assignment:
  - g0=0.
  - g1 = (dep(1,0) && !CHAIN_OK) ? 1 : 0.
  - g2 = max(dep(2,0) ? g0+1 : 0, dep(2,1) ? g1+1 : 0), computed with the collision rule applied.
  - Disabled slots get no group.
  - last = max group over enabled slots. Groups are contiguous, so there are never empty groups.
- Latency: accept at edge t. Group0 is registered at that edge and visible in cycle t+1 (iss_valid=1, iss_en = slots with g==0).
- State machine:
  - IDLE -> BUSY on accept with last>0. cur=1.
  - BUSY, !stall: emit group cur. cur++. When cur==last, go to IDLE at the same edge.
  - do_stall = (state==BUSY), registered and glitch-free.
- Back-to-back: in the cycle the final group is visible, do_stall=0, so a new bundle may be accepted. Its group0 follows with no bubble.
- No accept and not BUSY: iss_valid=0, iss_en=0, all forward/prev flags 0. do_split holds until next accept.
- Forward and bypass flags:
  - iss_fwdA[1]/iss_fwdB[1] = 1 iff slots 1 and 0 issue in the same group and the matching operand depends on slot0.
  - iss_prev{A,B}[k] = 1 iff slot k issues now and its producer for that operand issued in group cur-1.
  - Producer two groups earlier (g2=2, producer slot0) is read from the regfile; the flag is 0.
- do_split: registered on accept. Bit k = en_k && g_k>0.
- stall=1 freezes every register, including outputs and state. The consumer is frozen too, so no double issue.
- An op whose rA==rB==producer tag sets both A and B flags.

Test Plan:
- en=111, wen=111, idx=2/1/0, no tag matches -> t+1: iss_en=111, do_split=000, fwd/prev=0; do_stall never 1.
- CHAIN_OK=1, rA1=6'b110000 (tag0) -> single group; t+1: iss_en=111, iss_fwdA=010; do_stall stays 0.
- CHAIN_OK=1, rA1=tag0, rB2=tag1 -> t+1: iss_en=011, iss_fwdA=010, do_stall=1, do_split=100; t+2: iss_en=100, iss_prevB=100, do_stall=0; new bundle accepted at t+2 shows at t+3.
- CHAIN_OK=0, chain 0->1->2 via rA -> iss_en 001, 010, 100 on t+1..t+3; iss_prevA 000, 010, 100; do_stall=1 on t+1,t+2; do_split=110.
- CHAIN_OK=0, rA1=tag0 and rA2=tag0 -> two groups: 001 then 110 with iss_prevA=110. Same stimulus with stall=1 at t+1 for 2 cycles -> outputs hold 001; 110 appears after stall drops.
- Scenario 4 with rst low at t+2 -> all outputs 0 asynchronously; after release: iss_valid=0, do_stall=0, next bundle accepted normally.

Source files
------------

// File: rtl/alu_split_sched.sv
// Issue-split scheduler for the three-slot ALU: splits a bundle into dependency-ordered
// issue groups on consecutive cycles and produces same-group forward / previous-group bypass selects.

module alu_split_lane #(
    parameter int LANE = 0
) (
    input  logic             en_i,
    input  logic [5:0]       ra_i,
    input  logic [5:0]       rb_i,
    input  logic [2:0]       wr_ok_i,
    input  logic [2:0][5:0]  tag_i,
    output logic [2:0]       ma_o,
    output logic [2:0]       mb_o
);
    localparam logic [2:0] OLDER = 3'((1 << LANE) - 1);

    logic [2:0] eq_a, eq_b;

    for (genvar i = 0; i < 3; i++) begin : g_eq
        assign eq_a[i] = (ra_i == tag_i[i]);
        assign eq_b[i] = (rb_i == tag_i[i]);
    end

    // Only older, enabled, writing slots can be producers for this lane.
    assign ma_o = {3{en_i}} & wr_ok_i & OLDER & eq_a;
    assign mb_o = {3{en_i}} & wr_ok_i & OLDER & eq_b;
endmodule

module alu_split_sched #(
    parameter logic [3:0] TAG_HI   = 4'b1100,
    parameter bit         CHAIN_OK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        bnd_valid,
    input  logic [2:0]  slot_en,
    input  logic [2:0]  slot_wen,
    input  logic [5:0]  slot_index,
    input  logic [17:0] slot_rA,
    input  logic [17:0] slot_rB,
    output logic        do_stall,
    output logic [2:0]  do_split,
    output logic        iss_valid,
    output logic [2:0]  iss_en,
    output logic [2:0]  iss_fwdA,
    output logic [2:0]  iss_fwdB,
    output logic [2:0]  iss_prevA,
    output logic [2:0]  iss_prevB
);
    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [2:0] en;
        logic [1:0] g1;
        logic [1:0] g2;
        logic [1:0] last;
        logic [2:0] prev_a;
        logic [2:0] prev_b;
    } bnd_t;

    state_t          state_q;
    bnd_t            bnd_q, bnd_d;
    logic [1:0]      cur_q;
    logic            do_stall_q, iss_valid_q;
    logic [2:0]      do_split_q, iss_en_q, fwd_a_q, fwd_b_q, prev_a_q, prev_b_q;

    logic [2:0]      wr_ok;
    logic [2:0][5:0] tag;
    logic [2:0][2:0] ma, mb;
    logic            accept, coll;
    logic            d10a, d10b, d20a, d20b, d21a, d21b, dep10, dep20, dep21;
    logic [1:0]      g1, g2, g2_0, g2_1, l1, l2;
    logic [2:0]      fwd_a, fwd_b, split, en_g0, en_cur;

    assign wr_ok  = slot_en & slot_wen;
    assign accept = bnd_valid && !do_stall_q && !stall;

    for (genvar k = 0; k < 3; k++) begin : g_lane
        assign tag[k] = {TAG_HI, slot_index[2*k +: 2]};
        alu_split_lane #(.LANE(k)) u_lane (
            .en_i    (slot_en[k]),
            .ra_i    (slot_rA[6*k +: 6]),
            .rb_i    (slot_rB[6*k +: 6]),
            .wr_ok_i (wr_ok),
            .tag_i   (tag),
            .ma_o    (ma[k]),
            .mb_o    (mb[k])
        );
    end

    logic unused_m;
    assign unused_m = ^{ma[0], mb[0], ma[1][2:1], mb[1][2:1], ma[2][2], mb[2][2]};

    always_comb begin
        // Equal tags on slots 0/1: slot2 binds to the younger producer only.
        coll  = wr_ok[0] && wr_ok[1] && (slot_index[1:0] == slot_index[3:2]);
        d10a  = ma[1][0];
        d10b  = mb[1][0];
        d20a  = ma[2][0] && !coll;
        d20b  = mb[2][0] && !coll;
        d21a  = ma[2][1];
        d21b  = mb[2][1];
        dep10 = d10a || d10b;
        dep20 = d20a || d20b;
        dep21 = d21a || d21b;

        g1   = (dep10 && !CHAIN_OK) ? 2'd1 : 2'd0;
        g2_0 = dep20 ? 2'd1 : 2'd0;
        g2_1 = dep21 ? g1 + 2'd1 : 2'd0;
        g2   = (g2_1 > g2_0) ? g2_1 : g2_0;
        l1   = slot_en[1] ? g1 : 2'd0;
        l2   = slot_en[2] ? g2 : 2'd0;

        bnd_d.en     = slot_en;
        bnd_d.g1     = g1;
        bnd_d.g2     = g2;
        bnd_d.last   = (l2 > l1) ? l2 : l1;
        bnd_d.prev_a = {(d21a && g2 == g1 + 2'd1) || (d20a && g2 == 2'd1), d10a && g1 == 2'd1, 1'b0};
        bnd_d.prev_b = {(d21b && g2 == g1 + 2'd1) || (d20b && g2 == 2'd1), d10b && g1 == 2'd1, 1'b0};

        fwd_a  = {1'b0, d10a && g1 == 2'd0, 1'b0};
        fwd_b  = {1'b0, d10b && g1 == 2'd0, 1'b0};
        split  = {slot_en[2] && g2 != 2'd0, slot_en[1] && g1 != 2'd0, 1'b0};
        en_g0  = slot_en & {g2 == 2'd0, g1 == 2'd0, 1'b1};
        en_cur = bnd_q.en & {bnd_q.g2 == cur_q, bnd_q.g1 == cur_q, 1'b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bnd_q       <= '0;
            cur_q       <= 2'd0;
            do_stall_q  <= 1'b0;
            do_split_q  <= 3'b000;
            iss_valid_q <= 1'b0;
            iss_en_q    <= 3'b000;
            fwd_a_q     <= 3'b000;
            fwd_b_q     <= 3'b000;
            prev_a_q    <= 3'b000;
            prev_b_q    <= 3'b000;
        end else if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bnd_q       <= bnd_d;
                        do_split_q  <= split;
                        iss_valid_q <= 1'b1;
                        iss_en_q    <= en_g0;
                        fwd_a_q     <= fwd_a;
                        fwd_b_q     <= fwd_b;
                        prev_a_q    <= 3'b000;
                        prev_b_q    <= 3'b000;
                        if (bnd_d.last != 2'd0) begin
                            state_q    <= BUSY;
                            cur_q      <= 2'd1;
                            do_stall_q <= 1'b1;
                        end
                    end else begin
                        iss_valid_q <= 1'b0;
                        iss_en_q    <= 3'b000;
                        fwd_a_q     <= 3'b000;
                        fwd_b_q     <= 3'b000;
                        prev_a_q    <= 3'b000;
                        prev_b_q    <= 3'b000;
                    end
                end
                BUSY: begin
                    iss_valid_q <= 1'b1;
                    iss_en_q    <= en_cur;
                    fwd_a_q     <= 3'b000;
                    fwd_b_q     <= 3'b000;
                    prev_a_q    <= bnd_q.prev_a & en_cur;
                    prev_b_q    <= bnd_q.prev_b & en_cur;
                    if (cur_q == bnd_q.last) begin
                        state_q    <= IDLE;
                        do_stall_q <= 1'b0;
                    end else begin
                        cur_q <= cur_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign do_stall  = do_stall_q;
    assign do_split  = do_split_q;
    assign iss_valid = iss_valid_q;
    assign iss_en    = iss_en_q;
    assign iss_fwdA  = fwd_a_q;
    assign iss_fwdB  = fwd_b_q;
    assign iss_prevA = prev_a_q;
    assign iss_prevB = prev_b_q;
endmodule

// File: tb/tb_alu_split_sched.sv
// Directed bench: one instance with same-group chaining, one without, driven by shared stimulus.

module tb_alu_split_sched;
    localparam logic [5:0] T0  = 6'h30;
    localparam logic [5:0] T1  = 6'h31;
    localparam logic [5:0] IDX = 6'b10_01_00;

    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, bnd_valid = 1'b0;
    logic [2:0]  slot_en = '0, slot_wen = '0;
    logic [5:0]  slot_index = '0;
    logic [17:0] slot_rA = '0, slot_rB = '0;

    logic [1:0]      ds, iv;
    logic [1:0][2:0] sp, ie, fa, fb, pa, pb;

    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    // Instance 1: CHAIN_OK=1, instance 0: CHAIN_OK=0
    alu_split_sched #(.CHAIN_OK(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .stall(stall), .bnd_valid(bnd_valid), .slot_en(slot_en),
        .slot_wen(slot_wen), .slot_index(slot_index), .slot_rA(slot_rA), .slot_rB(slot_rB),
        .do_stall(ds[1]), .do_split(sp[1]), .iss_valid(iv[1]), .iss_en(ie[1]),
        .iss_fwdA(fa[1]), .iss_fwdB(fb[1]), .iss_prevA(pa[1]), .iss_prevB(pb[1]));

    alu_split_sched #(.CHAIN_OK(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .stall(stall), .bnd_valid(bnd_valid), .slot_en(slot_en),
        .slot_wen(slot_wen), .slot_index(slot_index), .slot_rA(slot_rA), .slot_rB(slot_rB),
        .do_stall(ds[0]), .do_split(sp[0]), .iss_valid(iv[0]), .iss_en(ie[0]),
        .iss_fwdA(fa[0]), .iss_fwdB(fb[0]), .iss_prevA(pa[0]), .iss_prevB(pb[0]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    // {valid, en, fwdA, fwdB, prevA, prevB, do_stall} of instance d
    task automatic ex(input int d, input string tag, input logic v, input logic [2:0] en,
                      input logic [2:0] efa, input logic [2:0] efb, input logic [2:0] epa,
                      input logic [2:0] epb, input logic st);
        chk(tag, {15'd0, iv[d], ie[d], fa[d], fb[d], pa[d], pb[d], ds[d]},
                 {15'd0, v, en, efa, efb, epa, epb, st});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bnd(input logic [2:0] en, input logic [5:0] idx,
                       input logic [17:0] ra, input logic [17:0] rb);
        bnd_valid = 1'b1; slot_en = en; slot_wen = 3'b111;
        slot_index = idx; slot_rA = ra; slot_rB = rb;
    endtask

    task automatic settle();
        bnd_valid = 1'b0;
        tick(); tick();
    endtask

    initial begin
        #1 rst = 1'b0;
        #3;
        ex(1, "rst_d1", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        ex(0, "rst_d0", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        chk("rst_split", {26'd0, sp[1], sp[0]}, 32'd0);
        @(negedge clk) rst = 1'b1;
        tick();

        // Independent ops: one group everywhere
        bnd(3'b111, IDX, {6'd3, 6'd2, 6'd1}, {6'd6, 6'd5, 6'd4});
        tick(); bnd_valid = 1'b0;
        ex(1, "indep_d1", 1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        ex(0, "indep_d0", 1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        chk("indep_split", {29'd0, sp[1]}, 32'd0);
        tick();
        ex(1, "indep_idle", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        settle();

        // rA1 = tag0: chained in d1, split in d0
        bnd(3'b111, IDX, {6'd3, T0, 6'd1}, {6'd6, 6'd5, 6'd4});
        tick(); bnd_valid = 1'b0;
        ex(1, "chain_d1", 1'b1, 3'b111, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0);
        ex(0, "chain_d0_g0", 1'b1, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
        chk("chain_d0_split", {29'd0, sp[0]}, 32'b010);
        tick();
        ex(1, "chain_d1_idle", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        ex(0, "chain_d0_g1", 1'b1, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 1'b0);
        settle();

        // rA1 = tag0, rB2 = tag1, then a back-to-back bundle held by do_stall
        bnd(3'b111, IDX, {6'd3, T0, 6'd1}, {T1, 6'd5, 6'd4});
        tick();
        ex(1, "b2b_g0", 1'b1, 3'b011, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1);
        chk("b2b_split", {29'd0, sp[1]}, 32'b100);
        ex(0, "b2b_d0_g0", 1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
        bnd(3'b101, IDX, {6'd3, 6'd2, 6'd1}, {6'd6, 6'd5, 6'd4});
        tick();
        ex(1, "b2b_g1", 1'b1, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 1'b0);
        ex(0, "b2b_d0_g1", 1'b1, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 1'b1);
        tick(); bnd_valid = 1'b0;
        ex(1, "b2b_next", 1'b1, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        chk("b2b_next_split", {29'd0, sp[1]}, 32'b000);
        ex(0, "b2b_d0_g2", 1'b1, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 1'b0);
        settle();

        // Full chain 0->1->2 via rA
        bnd(3'b111, IDX, {T1, T0, 6'd1}, {6'd6, 6'd5, 6'd4});
        tick(); bnd_valid = 1'b0;
        ex(0, "c3_g0", 1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
        chk("c3_split", {29'd0, sp[0]}, 32'b110);
        ex(1, "c3_d1_g0", 1'b1, 3'b011, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1);
        tick();
        ex(0, "c3_g1", 1'b1, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 1'b1);
        ex(1, "c3_d1_g1", 1'b1, 3'b100, 3'b000, 3'b000, 3'b100, 3'b000, 1'b0);
        tick();
        ex(0, "c3_g2", 1'b1, 3'b100, 3'b000, 3'b000, 3'b100, 3'b000, 1'b0);
        settle();

        // rA1 = rA2 = tag0, no stall
        bnd(3'b111, IDX, {T0, T0, 6'd1}, {6'd6, 6'd5, 6'd4});
        tick(); bnd_valid = 1'b0;
        ex(0, "fan_g0", 1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
        ex(1, "fan_d1_g0", 1'b1, 3'b011, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1);
        tick();
        ex(0, "fan_g1", 1'b1, 3'b110, 3'b000, 3'b000, 3'b110, 3'b000, 1'b0);
        ex(1, "fan_d1_g1", 1'b1, 3'b100, 3'b000, 3'b000, 3'b100, 3'b000, 1'b0);
        settle();

        // Same bundle with stall held for two cycles after accept
        bnd(3'b111, IDX, {T0, T0, 6'd1}, {6'd6, 6'd5, 6'd4});
        tick(); bnd_valid = 1'b0; stall = 1'b1;
        ex(0, "stl_t1", 1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
        tick();
        ex(0, "stl_t2", 1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
        tick(); stall = 1'b0;
        ex(0, "stl_t3", 1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
        tick();
        ex(0, "stl_t4", 1'b1, 3'b110, 3'b000, 3'b000, 3'b110, 3'b000, 1'b0);
        settle();

        // Tag collision idx1==idx0: slot2 binds to slot1; slot1 reads slot0 via rB
        bnd(3'b111, 6'b10_00_00, {T0, 6'd2, 6'd1}, {6'd6, T0, 6'd4});
        tick(); bnd_valid = 1'b0;
        ex(0, "col_g0", 1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
        ex(1, "col_d1_g0", 1'b1, 3'b011, 3'b000, 3'b010, 3'b000, 3'b000, 1'b1);
        tick();
        ex(0, "col_g1", 1'b1, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 1'b1);
        ex(1, "col_d1_g1", 1'b1, 3'b100, 3'b000, 3'b000, 3'b100, 3'b000, 1'b0);
        tick();
        ex(0, "col_g2", 1'b1, 3'b100, 3'b000, 3'b000, 3'b100, 3'b000, 1'b0);
        settle();

        // Chain again, reset asserted mid-split
        bnd(3'b111, IDX, {T1, T0, 6'd1}, {6'd6, 6'd5, 6'd4});
        tick(); bnd_valid = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        ex(0, "arst_d0", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        ex(1, "arst_d1", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        chk("arst_split", {26'd0, sp[1], sp[0]}, 32'd0);
        @(negedge clk) rst = 1'b1;
        tick();
        ex(0, "post_rst", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        bnd(3'b111, IDX, {6'd3, 6'd2, 6'd1}, {6'd6, 6'd5, 6'd4});
        tick(); bnd_valid = 1'b0;
        ex(0, "post_rst_bnd", 1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
